// File: rtl/pu_pkg.sv
// Shared types for the pixel-window controller: FSM state and horizontal stride encoding.
package pu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } pu_state_e;

    typedef enum logic {
        STRIDE_1 = 1'b0,
        STRIDE_2 = 1'b1
    } pu_stride_e;

    function automatic pu_stride_e stride_from_cfg(input logic stride2);
        return stride2 ? STRIDE_2 : STRIDE_1;
    endfunction

endpackage

// File: rtl/pu_window_ctrl_if.sv
// Frame control, column input stream and window output stream of pu_window_ctrl.
interface pu_window_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int K      = 5,
    parameter int CNT_W  = 8
);
    logic                    start;
    logic [CNT_W-1:0]        cfg_cols;
    logic [CNT_W-1:0]        cfg_rows;
    logic                    cfg_stride2;
    logic                    col_valid;
    logic [DATA_W*K-1:0]     col_data;
    logic                    col_ready;
    logic                    win_valid;
    logic [DATA_W*K*K-1:0]   win_data;
    logic                    win_ready;
    logic                    busy;
    logic                    done;
    logic                    cfg_err;

    // master drives frames and columns and consumes windows; slave is the controller
    modport master (
        output start, cfg_cols, cfg_rows, cfg_stride2, col_valid, col_data, win_ready,
        input  col_ready, win_valid, win_data, busy, done, cfg_err
    );

    modport slave (
        input  start, cfg_cols, cfg_rows, cfg_stride2, col_valid, col_data, win_ready,
        output col_ready, win_valid, win_data, busy, done, cfg_err
    );
endinterface

// File: rtl/pu_col_bank.sv
// K-column shift bank: new column enters at c = K-1, oldest column at c = 0 drops out.
module pu_col_bank #(
    parameter int DATA_W = 16,
    parameter int K      = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  shift_en,
    input  logic [DATA_W*K-1:0]   col_in,
    output logic [DATA_W*K*K-1:0] win
);

    logic [DATA_W*K*K-1:0] bank_q;
    logic [DATA_W*K*K-1:0] bank_d;

    always_comb begin
        // NOTE: bank_d starts as bank_q so the loop below can never infer a latch.
        bank_d = bank_q;
        if (shift_en) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    if (c == K - 1) begin
                        bank_d[(r*K + c)*DATA_W +: DATA_W] = col_in[r*DATA_W +: DATA_W];
                    end else begin
                        bank_d[(r*K + c)*DATA_W +: DATA_W] = bank_q[(r*K + c + 1)*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the pixel storage is reset as well, so win_data reads zero after rst.
            bank_q <= '0;
        end else begin
            bank_q <= bank_d;
        end
    end

    assign win = bank_q;

endmodule

// File: rtl/pu_window_ctrl.sv
// Sliding KxK window controller: fills a column bank per row and streams windows at stride 1 or 2.
module pu_window_ctrl
    import pu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int K      = 5,
    parameter int CNT_W  = 8
) (
    input  logic            clk,
    input  logic            rst,
    pu_window_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] K_CNT = CNT_W'(K);

    pu_state_e        state_q,   state_d;
    pu_stride_e       stride_q,  stride_d;
    logic [CNT_W-1:0] cols_q,    cols_d;
    logic [CNT_W-1:0] rows_q,    rows_d;
    logic [CNT_W-1:0] col_cnt_q, col_cnt_d;
    logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
    logic             phase_q,   phase_d;
    logic             drain_q,   drain_d;
    logic             win_valid_q, win_valid_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             cfg_err_q, cfg_err_d;

    logic             col_ready;
    logic             accept;
    logic             emit;
    logic [CNT_W-1:0] col_next;
    logic [CNT_W-1:0] row_next;
    logic [DATA_W*K*K-1:0] bank_win;

    always_comb begin
        state_d     = state_q;
        stride_d    = stride_q;
        cols_d      = cols_q;
        rows_d      = rows_q;
        col_cnt_d   = col_cnt_q;
        row_cnt_d   = row_cnt_q;
        phase_d     = phase_q;
        drain_d     = drain_q;
        cfg_err_d   = 1'b0;
        emit        = 1'b0;
        col_next    = col_cnt_q + 1'b1;
        row_next    = row_cnt_q + 1'b1;

        // A pending window blocks new columns so the bank (and win_data) cannot move under it.
        col_ready   = ((state_q == ST_FILL) || ((state_q == ST_STREAM) && !drain_q)) &&
                      (!win_valid_q || bus.win_ready);
        accept      = bus.col_valid && col_ready;
        win_valid_d = win_valid_q && !bus.win_ready;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if ((bus.cfg_cols >= K_CNT) && (bus.cfg_rows != '0)) begin
                        cols_d    = bus.cfg_cols;
                        rows_d    = bus.cfg_rows;
                        stride_d  = stride_from_cfg(bus.cfg_stride2);
                        col_cnt_d = '0;
                        row_cnt_d = '0;
                        phase_d   = 1'b0;
                        drain_d   = 1'b0;
                        state_d   = ST_FILL;
                    end else begin
                        cfg_err_d = 1'b1;
                        state_d   = ST_DONE;
                    end
                end
            end

            ST_FILL: begin
                if (accept) begin
                    col_cnt_d = col_next;
                    if (col_next == K_CNT) begin
                        emit    = 1'b1;
                        phase_d = 1'b0;
                        state_d = ST_STREAM;
                    end
                end
            end

            ST_STREAM: begin
                if (drain_q) begin
                    // Final window of the frame is out; leave only once it is taken.
                    if (!win_valid_q || bus.win_ready) begin
                        drain_d = 1'b0;
                        state_d = ST_DONE;
                    end
                end else if (accept) begin
                    col_cnt_d = col_next;
                    emit      = (stride_q == STRIDE_1) || phase_q;
                    phase_d   = !phase_q;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // End of row: the fill count restarts whether the last column made a window or not.
        if (accept && (col_next == cols_q)) begin
            col_cnt_d = '0;
            if (row_next == rows_q) begin
                if (emit) begin
                    drain_d = 1'b1;
                    state_d = ST_STREAM;
                end else begin
                    state_d = ST_DONE;
                end
            end else begin
                row_cnt_d = row_next;
                state_d   = ST_FILL;
            end
        end

        if (emit) begin
            win_valid_d = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            stride_q    <= STRIDE_1;
            cols_q      <= '0;
            rows_q      <= '0;
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            phase_q     <= 1'b0;
            drain_q     <= 1'b0;
            win_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stride_q    <= stride_d;
            cols_q      <= cols_d;
            rows_q      <= rows_d;
            col_cnt_q   <= col_cnt_d;
            row_cnt_q   <= row_cnt_d;
            phase_q     <= phase_d;
            drain_q     <= drain_d;
            win_valid_q <= win_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    pu_col_bank #(
        .DATA_W (DATA_W),
        .K      (K)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .shift_en (accept),
        .col_in   (bus.col_data),
        .win      (bank_win)
    );

    assign bus.col_ready = col_ready;
    assign bus.win_valid = win_valid_q;
    assign bus.win_data  = bank_win;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_pu_window_ctrl.sv
// Self-checking bench for pu_window_ctrl (K = 3): vector table, corner sequences and random frames.
module tb_pu_window_ctrl;

    localparam int DW  = 8;
    localparam int KK  = 3;
    localparam int CW  = 8;
    localparam int WW  = DW*KK*KK;
    localparam int CWD = DW*KK;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pu_window_ctrl_if #(.DATA_W(DW), .K(KK), .CNT_W(CW)) bus ();

    pu_window_ctrl #(.DATA_W(DW), .K(KK), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int cols;
        int rows;
        bit s2;
        bit seq;
        int ready_pct;
        int stall_win;
        int stall_len;
        int exp_win;
        bit exp_err;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    logic [CWD-1:0] col_mem [$];
    logic [WW-1:0]  exp_q   [$];

    task automatic check(input string name, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference: every legal window start s = 0, stride, ... with s+K <= cols, per row.
    task automatic build_model(input int cols, input int rows, input bit s2);
        int stride;
        stride = s2 ? 2 : 1;
        exp_q.delete();
        if (cols < KK || rows < 1) return;
        for (int row = 0; row < rows; row++) begin
            for (int s = 0; s + KK <= cols; s += stride) begin
                logic [WW-1:0]  w;
                logic [CWD-1:0] col;
                w = '0;
                for (int c = 0; c < KK; c++) begin
                    col = col_mem[row*cols + s + c];
                    for (int r = 0; r < KK; r++) w[(r*KK + c)*DW +: DW] = col[r*DW +: DW];
                end
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic run_frame(input string tag, input int cols, input int rows, input bit s2,
                             input bit seq, input int ready_pct, input int stall_win,
                             input int stall_len, output int n_win, output int n_acc,
                             output bit done_seen, output bit err_seen);
        int idx;
        int stall_cnt;
        int cyc;
        bit stall_ok;
        bit prev_hold;
        logic [WW-1:0] prev_data;
        logic [DW-1:0] px;
        idx = 0; stall_cnt = 0; cyc = 0; stall_ok = 1'b1; prev_hold = 1'b0; prev_data = '0;
        n_win = 0; n_acc = 0; done_seen = 1'b0; err_seen = 1'b0;
        col_mem.delete();
        for (int n = 0; n < cols*rows; n++) begin
            px = DW'(n);
            col_mem.push_back(seq ? {KK{px}} : CWD'($urandom));
        end
        build_model(cols, rows, s2);

        @(negedge clk);
        bus.cfg_cols    = CW'(cols);
        bus.cfg_rows    = CW'(rows);
        bus.cfg_stride2 = s2;
        bus.start       = 1'b1;
        @(negedge clk);
        bus.start       = 1'b0;
        bus.cfg_cols    = CW'($urandom);
        bus.cfg_rows    = CW'($urandom);
        bus.cfg_stride2 = 1'($urandom);
        check({tag, " busy"}, WW'(bus.busy), WW'(1));

        while (cyc < 3000) begin
            bus.col_valid = ($urandom_range(0, 99) < 80);
            bus.col_data  = (idx < col_mem.size()) ? col_mem[idx] : CWD'($urandom);
            bus.start     = ($urandom_range(0, 19) == 0);
            if (bus.win_valid && stall_win == n_win && stall_cnt < stall_len) begin
                bus.win_ready = 1'b0;
                stall_cnt++;
            end else begin
                bus.win_ready = ($urandom_range(0, 99) < ready_pct);
            end
            #1;
            if (prev_hold && bus.win_data !== prev_data) stall_ok = 1'b0;
            if (bus.win_valid && !bus.win_ready && bus.col_ready) stall_ok = 1'b0;
            if (stall_cnt > 0 && stall_cnt <= stall_len && stall_win == n_win && !bus.win_ready) begin
                check($sformatf("%s stall%0d col_ready", tag, stall_cnt), WW'(bus.col_ready), WW'(0));
                if (exp_q.size() > 0)
                    check($sformatf("%s stall%0d data", tag, stall_cnt), bus.win_data, exp_q[0]);
            end
            prev_hold = bus.win_valid && !bus.win_ready;
            prev_data = bus.win_data;
            if (bus.col_valid && bus.col_ready) begin
                n_acc++;
                idx++;
            end
            if (bus.win_valid && bus.win_ready) begin
                if (exp_q.size() > 0)
                    check($sformatf("%s win%0d", tag, n_win), bus.win_data, exp_q.pop_front());
                n_win++;
            end
            if (bus.done) begin
                done_seen = 1'b1;
                err_seen  = bus.cfg_err;
            end
            @(negedge clk);
            cyc++;
            if (done_seen) break;
        end
        bus.start     = 1'b0;
        bus.col_valid = 1'b0;
        bus.win_ready = 1'b0;

        check({tag, " done"}, WW'(done_seen), WW'(1));
        check({tag, " stable_hold"}, WW'(stall_ok), WW'(1));
        if (done_seen) begin
            check({tag, " idle_busy"}, WW'(bus.busy), WW'(0));
            check({tag, " done_pulse"}, WW'(bus.done), WW'(0));
        end else begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
    endtask

    vec_t vecs [10];

    initial begin
        int  n_win, n_acc, cols, rows, stride, exp_win, wait_cyc;
        bit  done_seen, err_seen, s2;

        vecs[0] = '{5,  1, 1'b0, 1'b1, 100, -1, 0, 3,  1'b0};
        vecs[1] = '{5,  1, 1'b0, 1'b1, 100,  1, 4, 3,  1'b0};
        vecs[2] = '{7,  1, 1'b1, 1'b1, 100, -1, 0, 3,  1'b0};
        vecs[3] = '{4,  2, 1'b0, 1'b1, 100, -1, 0, 4,  1'b0};
        vecs[4] = '{2,  1, 1'b0, 1'b1, 100, -1, 0, 0,  1'b1};
        vecs[5] = '{5,  0, 1'b0, 1'b1, 100, -1, 0, 0,  1'b1};
        vecs[6] = '{3,  2, 1'b1, 1'b0, 60,  -1, 0, 2,  1'b0};
        vecs[7] = '{8,  1, 1'b1, 1'b0, 50,  -1, 0, 3,  1'b0};
        vecs[8] = '{10, 3, 1'b0, 1'b0, 40,  -1, 0, 24, 1'b0};
        vecs[9] = '{9,  2, 1'b1, 1'b0, 70,  -1, 0, 8,  1'b0};

        rst = 1'b1;
        bus.start = 1'b0; bus.cfg_cols = '0; bus.cfg_rows = '0; bus.cfg_stride2 = 1'b0;
        bus.col_valid = 1'b0; bus.col_data = '0; bus.win_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy",      WW'(bus.busy),      WW'(0));
        check("reset win_valid", WW'(bus.win_valid), WW'(0));
        check("reset col_ready", WW'(bus.col_ready), WW'(0));
        check("reset done",      WW'(bus.done),      WW'(0));
        check("reset cfg_err",   WW'(bus.cfg_err),   WW'(0));
        check("reset win_data",  bus.win_data,       WW'(0));
        rst = 1'b0;

        for (int v = 0; v < 10; v++) begin
            run_frame($sformatf("vec%0d", v), vecs[v].cols, vecs[v].rows, vecs[v].s2, vecs[v].seq,
                      vecs[v].ready_pct, vecs[v].stall_win, vecs[v].stall_len,
                      n_win, n_acc, done_seen, err_seen);
            check($sformatf("vec%0d windows", v), WW'(n_win), WW'(vecs[v].exp_win));
            check($sformatf("vec%0d cfg_err", v), WW'(err_seen), WW'(vecs[v].exp_err));
            check($sformatf("vec%0d cols_accepted", v), WW'(n_acc),
                  WW'(vecs[v].exp_err ? 0 : vecs[v].cols * vecs[v].rows));
        end

        // Reset in the middle of streaming, then a clean frame.
        @(negedge clk);
        bus.cfg_cols = CW'(6); bus.cfg_rows = CW'(2); bus.cfg_stride2 = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.col_valid = 1'b1; bus.win_ready = 1'b0;
        wait_cyc = 0;
        while (!bus.win_valid && wait_cyc < 50) begin
            bus.col_data = CWD'($urandom);
            @(negedge clk);
            wait_cyc++;
        end
        check("midrst win_valid_seen", WW'(bus.win_valid), WW'(1));
        rst = 1'b1;
        @(negedge clk);
        check("midrst busy",      WW'(bus.busy),      WW'(0));
        check("midrst win_valid", WW'(bus.win_valid), WW'(0));
        check("midrst col_ready", WW'(bus.col_ready), WW'(0));
        check("midrst done",      WW'(bus.done),      WW'(0));
        check("midrst win_data",  bus.win_data,       WW'(0));
        rst = 1'b0; bus.col_valid = 1'b0;
        run_frame("postrst", 5, 2, 1'b0, 1'b0, 80, -1, 0, n_win, n_acc, done_seen, err_seen);
        check("postrst windows", WW'(n_win), WW'(6));
        check("postrst cols_accepted", WW'(n_acc), WW'(10));

        // Random frames: expected count from floor((cols-K)/stride)+1 per row.
        for (int f = 0; f < 8; f++) begin
            cols   = $urandom_range(3, 12);
            rows   = $urandom_range(1, 3);
            s2     = 1'($urandom);
            stride = s2 ? 2 : 1;
            exp_win = rows * ((cols - KK) / stride + 1);
            run_frame($sformatf("rnd%0d", f), cols, rows, s2, 1'b0, $urandom_range(30, 100),
                      $urandom_range(0, 2), $urandom_range(0, 5), n_win, n_acc, done_seen, err_seen);
            check($sformatf("rnd%0d windows", f), WW'(n_win), WW'(exp_win));
            check($sformatf("rnd%0d cols_accepted", f), WW'(n_acc), WW'(cols * rows));
            check($sformatf("rnd%0d cfg_err", f), WW'(err_seen), WW'(0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pu_window_ctrl.md
PU_WINDOW_CTRL -- requirements
Module: pu_window_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, pixel width in bits.
REQ-002 SHALL have parameter K, default 5, square kernel size (2..7).
REQ-003 SHALL have parameter CNT_W, default 8, width of the column/row config counters.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle pulse, begins a frame (sampled in IDLE only).
REQ-007 SHALL have port cfg_cols  in  CNT_W  input columns per row.
REQ-008 SHALL have port cfg_rows  in  CNT_W  window rows per frame.
REQ-009 SHALL have port cfg_stride2  in  1  0 = stride 1, 1 = stride 2 (horizontal).
REQ-010 SHALL have port col_valid  in  1  new column present.
REQ-011 SHALL have port col_data  in  DATA_W*K  column; element r (top = 0) at bits [r*DATA_W +: DATA_W].
REQ-012 SHALL have port col_ready  out  1  column accepted when col_valid && col_ready.
REQ-013 SHALL have port win_valid  out  1  window present.
REQ-014 SHALL have port win_data  out  DATA_W*K*K  element (r,c) at index r*K+c; c = 0 is the oldest column.
REQ-015 SHALL have port win_ready  in  1  downstream accepts window.
REQ-016 SHALL have port busy  out  1  high outside IDLE.
REQ-017 SHALL have port done  out  1  one-cycle pulse at frame end.
REQ-018 SHALL have port cfg_err  out  1  one-cycle pulse when the frame is rejected.

Function
REQ-019 SHALL latch cfg_* on start in IDLE; later config changes have no effect until the next start.
REQ-020 SHALL implement states IDLE, FILL, STREAM, DONE.
REQ-021 IDLE->FILL on start when cfg_cols>=K and cfg_rows>=1; otherwise IDLE->DONE with a cfg_err pulse and no columns accepted.
REQ-022 SHALL hold a K-column shift bank; each accepted column shifts in at c = K-1 and drops c = 0, so only K new pixels are loaded per step (overlap reuse).
REQ-023 FILL: col_ready = 1; after K accepted columns, go to STREAM and present the first window of the row.
REQ-024 STREAM: col_ready = !win_valid || win_ready; the row's column count increments per accepted column.
REQ-025 A window SHALL be presented (win_valid = 1, registered) the cycle after accepting the completing column; latency is 1 cycle.
REQ-026 Stride 2: after the first window of a row, a window SHALL be emitted on every 2nd accepted column; intermediate columns shift in silently.
REQ-027 Windows per row SHALL be floor((cfg_cols-K)/stride)+1; trailing columns that complete no window are accepted and discarded.
REQ-028 While win_valid && !win_ready, win_data SHALL stay stable and col_ready SHALL stay 0.
REQ-029 Acceptance of the last column of a row (column count = cfg_cols) SHALL clear the bank fill count: go to FILL for the next row, or to DONE after row cfg_rows.
REQ-030 The last window of a row SHALL remain valid until it is accepted, independent of the FILL transition.
REQ-031 DONE SHALL be entered only after the final window is accepted; DONE pulses done for 1 cycle and then goes to IDLE.
REQ-032 start outside IDLE SHALL be ignored.
REQ-033 Counters SHALL be CNT_W bits wide and SHALL not wrap within a legal frame.

Reset
REQ-034 rst SHALL force IDLE, clear all counters, and drive win_valid, col_ready, busy, done and cfg_err to 0 on the next edge, including mid-frame.
REQ-035 win_data and the bank SHALL reset to zero.

Structure
REQ-036 The state enum and stride encoding SHALL live in shared package pu_pkg.
REQ-037 The column shift bank SHALL be the sub-module pu_col_bank (parameters DATA_W and K; ports shift_en and col_in; output is the flat window).

Verification
REQ-038 K=3, cols=5, rows=1, stride 1, col n = {n,n,n} for n = 0..4, win_ready = 1 -> 3 windows with columns {0,1,2}, {1,2,3}, {2,3,4}, then done.
REQ-039 Same frame, win_ready held 0 for 4 cycles on window 2 -> win_data stable, col_ready = 0 throughout, no data lost.
REQ-040 K=3, cols=7, stride 2 -> windows starting at columns 0, 2 and 4 (3 windows); column 6 is consumed and no 4th window is produced.
REQ-041 K=3, cols=4, rows=2 -> 2 windows per row; row 2 refills (3 columns, no window) before its first window; done after 4 windows.
REQ-042 rst asserted during STREAM -> next cycle busy = 0 and win_valid = 0; a new start runs a clean frame.
REQ-043 cols=2 with K=3 -> cfg_err and done pulse together, and no column is ever accepted.
